// File: rtl/cpu_pkg.sv
// Shared encodings for the control unit, its datapath and the bench.
//   state_t  : micro-state encoding driven on the 'state' output
//   opcode_t : instruction-register low nibble; unlisted values act as NOP
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_NEXT       = 4'h0,
        ST_FETCH_PC   = 4'h1,
        ST_FETCH_INST = 4'h2,
        ST_FETCH_ARG  = 4'h3,
        ST_LOAD_Z     = 4'h4,
        ST_RAM_A      = 4'h5,
        ST_RAM_B      = 4'h6,
        ST_ALU        = 4'h7,
        ST_OUT_A      = 4'h8,
        ST_JUMP_Z     = 4'h9,
        ST_HALT       = 4'hF
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_OUT = 4'h3,
        OP_JMP = 4'h4,
        OP_HLT = 4'h5
    } opcode_t;

endpackage

// File: rtl/alu_adder.sv
// Combinational ripple adder for the ALU datapath.
//   a, b, cin : operands and carry in
//   sum, cout : result modulo 2^WIDTH and carry out
module alu_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_control_unit.sv
// Micro-sequenced control unit for a small accumulator CPU plus its adder.
// A 4-bit micro-step counter is the only state; the micro-state and every
// control strobe are decoded combinationally from (opcode, cycle).
//   clk, reset       : rising-edge clock, async active-low reset
//   run              : counter enable
//   opcode           : instruction-register low nibble (held externally)
//   a, b, cin        : adder operands
//   sum, cout        : adder result
//   cycle, state     : micro-step counter and decoded micro-state
//   ai..zo,halt,next : control strobes
module alu_control_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       cycle,
    output logic [3:0]       state,
    output logic             ai,
    output logic             ao,
    output logic             bi,
    output logic             ci,
    output logic             co,
    output logic             eo,
    output logic             ii,
    output logic             j,
    output logic             mi,
    output logic             oi,
    output logic             ro,
    output logic             zi,
    output logic             zo,
    output logic             halt,
    output logic             next
);

    logic [3:0] cycle_q;
    state_t     st;
    opcode_t    op;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    assign op = opcode_t'(opcode);

    // Every opcode shares the two fetch steps; past its own list it falls to NEXT.
    always_comb begin
        st = ST_NEXT;
        if (cycle_q == 4'd0) begin
            st = ST_FETCH_PC;
        end else if (cycle_q == 4'd1) begin
            st = ST_FETCH_INST;
        end else begin
            case (op)
                OP_LDA: begin
                    case (cycle_q)
                        4'd2:    st = ST_FETCH_PC;
                        4'd3:    st = ST_FETCH_ARG;
                        4'd4:    st = ST_LOAD_Z;
                        4'd5:    st = ST_RAM_A;
                        default: st = ST_NEXT;
                    endcase
                end
                OP_ADD: begin
                    case (cycle_q)
                        4'd2:    st = ST_FETCH_PC;
                        4'd3:    st = ST_FETCH_ARG;
                        4'd4:    st = ST_LOAD_Z;
                        4'd5:    st = ST_RAM_B;
                        4'd6:    st = ST_ALU;
                        default: st = ST_NEXT;
                    endcase
                end
                OP_OUT: begin
                    if (cycle_q == 4'd2) st = ST_OUT_A;
                end
                OP_JMP: begin
                    case (cycle_q)
                        4'd2:    st = ST_FETCH_PC;
                        4'd3:    st = ST_JUMP_Z;
                        default: st = ST_NEXT;
                    endcase
                end
                OP_HLT: begin
                    if (cycle_q == 4'd2) st = ST_HALT;
                end
                default: st = ST_NEXT;
            endcase
        end
    end

    // HALT holds the counter, so the halted decode persists until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= 4'd0;
        end else if (run) begin
            if (st == ST_NEXT)
                cycle_q <= 4'd0;
            else if (st != ST_HALT)
                cycle_q <= cycle_q + 4'd1;
        end
    end

    assign cycle = cycle_q;
    assign state = st;

    assign ai   = (st == ST_RAM_A) || (st == ST_ALU);
    assign ao   = (st == ST_OUT_A);
    assign oi   = (st == ST_OUT_A);
    assign bi   = (st == ST_RAM_B);
    assign ci   = (st == ST_FETCH_INST) || (st == ST_FETCH_ARG) || (st == ST_JUMP_Z);
    assign co   = (st == ST_FETCH_PC);
    assign eo   = (st == ST_ALU);
    assign ii   = (st == ST_FETCH_INST);
    assign j    = (st == ST_JUMP_Z);
    assign mi   = (st == ST_FETCH_PC) || (st == ST_LOAD_Z);
    assign ro   = (st == ST_FETCH_INST) || (st == ST_FETCH_ARG) || (st == ST_JUMP_Z)
               || (st == ST_RAM_A) || (st == ST_RAM_B);
    assign zi   = (st == ST_FETCH_ARG);
    assign zo   = (st == ST_LOAD_Z);
    assign halt = (st == ST_HALT);
    assign next = (st == ST_NEXT) || !reset;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: directed literal checks, then random stimulus
// compared every negedge against a table-driven model of the micro-program.
module tb_alu_control_unit;
    localparam int WIDTH = 8;

    logic             clk, reset, run, cin;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a, b, sum;
    logic             cout;
    logic [3:0]       cycle, state;
    logic ai, ao, bi, ci, co, eo, ii, j, mi, oi, ro, zi, zo, halt, next;

    int   n_chk = 0;
    int   n_pass = 0;
    logic chk_en = 1'b0;
    logic [3:0] mcyc;

    alu_control_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .cycle(cycle), .state(state),
        .ai(ai), .ao(ao), .bi(bi), .ci(ci), .co(co), .eo(eo), .ii(ii), .j(j),
        .mi(mi), .oi(oi), .ro(ro), .zi(zi), .zo(zo), .halt(halt), .next(next)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Micro-program as a table: steps listed from cycle 2 onwards.
    function automatic int exp_state(int op, int cyc);
        int seq[$];
        if (cyc == 0) return 1;
        if (cyc == 1) return 2;
        case (op)
            1:       seq = '{1, 3, 4, 5};
            2:       seq = '{1, 3, 4, 6, 7};
            3:       seq = '{8};
            4:       seq = '{1, 9};
            5:       seq = '{15};
            default: seq = '{};
        endcase
        if (cyc - 2 < seq.size()) return seq[cyc - 2];
        return 0;
    endfunction

    // {ai,ao,bi,ci,co,eo,ii,j,mi,oi,ro,zi,zo,halt,next}
    function automatic logic [14:0] exp_strobes(int s, logic rst_n);
        logic [14:0] v;
        v[14] = (s == 5) || (s == 7);
        v[13] = (s == 8);
        v[12] = (s == 6);
        v[11] = (s == 2) || (s == 3) || (s == 9);
        v[10] = (s == 1);
        v[9]  = (s == 7);
        v[8]  = (s == 2);
        v[7]  = (s == 9);
        v[6]  = (s == 1) || (s == 4);
        v[5]  = (s == 8);
        v[4]  = (s == 2) || (s == 3) || (s == 9) || (s == 5) || (s == 6);
        v[3]  = (s == 3);
        v[2]  = (s == 4);
        v[1]  = (s == 15);
        v[0]  = (s == 0) || !rst_n;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference counter: reset to 0, advance by the expected micro-state.
    always @(posedge clk or negedge reset) begin
        if (!reset)
            mcyc <= 4'd0;
        else if (run) begin
            if (exp_state(int'(opcode), int'(mcyc)) == 0)
                mcyc <= 4'd0;
            else if (exp_state(int'(opcode), int'(mcyc)) != 15)
                mcyc <= mcyc + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int s, total;
            s = exp_state(int'(opcode), int'(mcyc));
            total = int'(a) + int'(b) + int'(cin);
            chk("m_cycle", int'(cycle), int'(mcyc));
            chk("m_state", int'(state), s);
            chk("m_strobes",
                int'({ai, ao, bi, ci, co, eo, ii, j, mi, oi, ro, zi, zo, halt, next}),
                int'(exp_strobes(s, reset)));
            chk("m_sum", int'({cout, sum}), total % (1 << (WIDTH + 1)));
        end
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic walk(input string name, input int exp[$]);
        foreach (exp[i]) begin
            if (i > 0) adv();
            chk(name, int'(state), exp[i]);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b1; opcode = 4'd0;
        a = '0; b = '0; cin = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_cycle", int'(cycle), 0);
        chk("rst_state", int'(state), 1);
        chk("rst_co_mi_next", int'({co, mi, next}), 7);
        chk("rst_sum", int'({cout, sum}), 0);

        adv();
        reset = 1'b1;
        #1;
        walk("nop_seq", '{1, 2, 0, 1, 2, 0});

        adv();
        opcode = 4'd2; a = 8'h05; b = 8'h03; cin = 1'b0;
        #1;
        walk("add_seq", '{1, 2, 1, 3, 4, 6, 7});
        chk("add_eo_ai", int'({eo, ai}), 3);
        chk("add_sum", int'(sum), 8);
        chk("add_cout", int'(cout), 0);
        adv();
        chk("add_next", int'(state), 0);
        a = 8'hFF; b = 8'h01; cin = 1'b1;
        #1;
        chk("wrap_sum", int'(sum), 1);
        chk("wrap_cout", int'(cout), 1);

        adv();
        opcode = 4'd4;
        #1;
        walk("jmp_seq", '{1, 2, 1, 9});
        chk("jmp_cycle", int'(cycle), 3);
        chk("jmp_ro_ci_j", int'({ro, ci, j}), 7);
        adv();
        chk("jmp_next", int'(state), 0);
        adv();
        chk("jmp_wrap", int'(cycle), 0);

        opcode = 4'd5;
        #1;
        walk("hlt_seq", '{1, 2, 15});
        chk("hlt_halt", int'(halt), 1);
        repeat (10) adv();
        chk("hlt_hold", int'(cycle), 2);
        chk("hlt_state", int'(state), 15);
        reset = 1'b0;
        #1;
        chk("hlt_rst", int'(cycle), 0);
        adv();
        reset = 1'b1; opcode = 4'd1;
        #1;
        repeat (4) adv();
        chk("lda_cycle", int'(cycle), 4);
        run = 1'b0;
        repeat (3) adv();
        chk("lda_hold", int'(cycle), 4);
        chk("lda_zo_mi", int'({zo, mi}), 3);
        run = 1'b1;
        adv();
        chk("lda_resume", int'(state), 5);

        repeat (3000) begin
            adv();
            if ($urandom_range(0, 3) == 0) opcode = 4'($urandom_range(0, 15));
            run = ($urandom_range(0, 7) != 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 59) == 0) reset = 1'b0;
        end
        adv();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_control_unit.md
ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning ALU datapath width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, ports listed below.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 run  input  1  clock enable; 0 freezes the cycle counter.
REQ-006 opcode  input  4  instruction-register low nibble.
REQ-007 a, b  input  WIDTH each  ALU operands (A and B register values).
REQ-008 cin  input  1  ALU carry in.
REQ-009 sum  output  WIDTH  ALU result; cout  output  1  ALU carry out.
REQ-010 cycle  output  4  micro-step counter; state  output  4  current micro-state.
REQ-011 ai, ao, bi, ci, co, eo, ii, j, mi, oi, ro, zi, zo, halt, next  output  1 each  control strobes.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin combinationally, wrapping modulo 2^WIDTH (0xFF+0x01+0 -> sum 0x00, cout 1).
REQ-013 State encoding SHALL be: NEXT 0, FETCH_PC 1, FETCH_INST 2, FETCH_ARG 3, LOAD_Z 4, RAM_A 5, RAM_B 6, ALU 7, OUT_A 8, JUMP_Z 9, HALT 0xF.
REQ-014 Opcodes SHALL be: NOP 0, LDA 1, ADD 2, OUT 3, JMP 4, HLT 5; all others behave as NOP.
REQ-015 state SHALL be a combinational function of (opcode, cycle): cycle 0 FETCH_PC, cycle 1 FETCH_INST regardless of opcode.
REQ-016 From cycle 2: NOP -> NEXT; LDA -> FETCH_PC, FETCH_ARG, LOAD_Z, RAM_A, NEXT; ADD -> FETCH_PC, FETCH_ARG, LOAD_Z, RAM_B, ALU, NEXT; OUT -> OUT_A, NEXT; JMP -> FETCH_PC, JUMP_Z, NEXT; HLT -> HALT.
REQ-017 Any cycle value past an opcode's listed sequence SHALL decode to NEXT.
REQ-018 Strobe decode: ai = RAM_A|ALU; ao = oi = OUT_A; bi = RAM_B; ci = FETCH_INST|FETCH_ARG|JUMP_Z; co = FETCH_PC; eo = ALU; ii = FETCH_INST; j = JUMP_Z; mi = FETCH_PC|LOAD_Z; ro = FETCH_INST|FETCH_ARG|JUMP_Z|RAM_A|RAM_B; zi = FETCH_ARG; zo = LOAD_Z; halt = HALT.
REQ-019 next SHALL be 1 when state == NEXT or reset is asserted (low).
REQ-020 On a rising clk edge with run=1: state NEXT -> cycle 0; state HALT -> cycle unchanged; otherwise cycle+1 (4-bit wrap).
REQ-021 With run=0 cycle SHALL hold; outputs remain the combinational decode of held cycle.
REQ-022 HALT SHALL be sticky until reset; opcode changes while halted do not exit HALT only if the new opcode also decodes HALT at that cycle (opcode is held externally).
REQ-023 Opcode SHALL be sampled combinationally each cycle; no internal copy.
REQ-024 All strobes SHALL be mutually consistent with exactly one state per cycle; no glitch-free guarantee beyond synchronous use.

Reset
REQ-025 reset low SHALL asynchronously force cycle = 0 (state FETCH_PC, co = mi = 1, next = 1).
REQ-026 Reset asserted mid-instruction SHALL abort it; after release the next enabled edge moves to cycle 1.
REQ-027 sum/cout SHALL be unaffected by reset (pure combinational).

Structure
REQ-028 Opcode and state encodings SHALL live in shared package cpu_pkg for the datapath and bench.
REQ-029 The adder SHALL be one sub-module alu_adder (WIDTH parameter); counter and decode are inline.

Verification
REQ-030 Reset low, run=1, opcode=0 -> cycle 0, state 1, co=mi=next=1; release -> states 1,2,0(NEXT),1 repeating.
REQ-031 opcode=2 (ADD), a=0x05, b=0x03, cin=0 -> states 1,2,1,3,4,6,7,0; in ALU step eo=ai=1, sum=0x08, cout=0.
REQ-032 a=0xFF, b=0x01, cin=1 -> sum 0x01, cout 1.
REQ-033 opcode=4 (JMP) -> state 9 at cycle 3 with ro=ci=j=1, then NEXT, cycle back to 0.
REQ-034 opcode=5 (HLT) -> state 0xF at cycle 2, halt=1, cycle holds for 10 edges; reset low -> cycle 0.
REQ-035 Mid-LDA (cycle 4) run=0 for 3 edges -> cycle stays 4, zo=mi=1; run=1 -> resumes at RAM_A.
